// File: rtl/pdp_read_burst_arbiter_pkg.sv
// Shared types, default widths and helpers for the PDP RAM read-burst arbiter.
// Arbitration policy is selected by PDP_ARB_ROUND_ROBIN_EN (see pdp_rr_select).
package pdp_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_ADDRESS_WIDTH = 16;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_REQUESTERS    = 4;
  localparam int DEF_LENGTH_WIDTH  = 8;
  localparam int MAX_REQUESTERS    = 8;
  localparam int IDX_WIDTH         = 3;

  // OR-reduces the set bit positions; exact for a one-hot input.
  function automatic logic [IDX_WIDTH-1:0] onehot_to_index(input logic [MAX_REQUESTERS-1:0] onehot);
    logic [IDX_WIDTH-1:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_REQUESTERS; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_WIDTH'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pdp_read_burst_arbiter_if.sv
// Client/RAM-side bundle of the read-burst arbiter; slave = arbiter, master = clients + RAM.
interface pdp_read_burst_arbiter_if
  import pdp_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int REQUESTERS    = DEF_REQUESTERS,
  parameter int LENGTH_WIDTH  = DEF_LENGTH_WIDTH
);

  logic [REQUESTERS-1:0]               Request_i;
  logic [REQUESTERS*ADDRESS_WIDTH-1:0] Address_i;
  logic [REQUESTERS*LENGTH_WIDTH-1:0]  Length_i;
  logic [DATA_WIDTH-1:0]               RamData_i;
  logic [REQUESTERS-1:0]               Ack_o;
  logic                                RamReadEnable_o;
  logic [ADDRESS_WIDTH-1:0]            RamReadAddress_o;
  logic [DATA_WIDTH-1:0]               Data_o;
  logic [REQUESTERS-1:0]               DataValid_o;
  logic                                Last_o;
  logic                                Busy_o;

  modport slave (
    input  Request_i, Address_i, Length_i, RamData_i,
    output Ack_o, RamReadEnable_o, RamReadAddress_o, Data_o, DataValid_o, Last_o, Busy_o
  );

  modport master (
    output Request_i, Address_i, Length_i, RamData_i,
    input  Ack_o, RamReadEnable_o, RamReadAddress_o, Data_o, DataValid_o, Last_o, Busy_o
  );

endinterface

// File: rtl/pdp_read_burst_arbiter_rr_select.sv
// Combinational winner select: round-robin from a pointer when PDP_ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with the lowest index winning.
module pdp_rr_select
  import pdp_arb_pkg::*;
#(
  parameter int REQUESTERS = DEF_REQUESTERS
) (
  input  logic [REQUESTERS-1:0] request,
`ifdef PDP_ARB_ROUND_ROBIN_EN
  input  logic [IDX_WIDTH-1:0]  pointer,
`endif
  output logic [REQUESTERS-1:0] grant
);

  logic blocked_s;

`ifdef PDP_ARB_ROUND_ROBIN_EN
  // Rank 0 is the client at the pointer, rising cyclically from there.
  function automatic int rank(input int idx);
    int r;
    r = idx - int'(pointer);
    if (r < 0) begin
      r = r + REQUESTERS;
    end else begin
      r = r;
    end
    return r;
  endfunction
`else
  function automatic int rank(input int idx);
    return idx;
  endfunction
`endif

  // A requester wins when no other requester holds a smaller rank.
  always_comb begin
    grant     = {REQUESTERS{1'b0}};
    blocked_s = 1'b0;
    for (int k = 0; k < REQUESTERS; k++) begin
      blocked_s = 1'b0;
      for (int j = 0; j < REQUESTERS; j++) begin
        if (request[j] && (rank(j) < rank(k))) begin
          blocked_s = 1'b1;
        end else begin
          blocked_s = blocked_s;
        end
      end
      grant[k] = request[k] & ~blocked_s;
    end
  end

endmodule

// File: rtl/pdp_read_burst_arbiter.sv
// Read-port arbiter for the pseudo-dual-port RAM: one burst at a time, sequential
// addresses wrapping at MEMORY_DEPTH, returned words tagged to the owner. Macro: PDP_ARB_ROUND_ROBIN_EN.
module pdp_read_burst_arbiter
  import pdp_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MEMORY_DEPTH  = 2 ** ADDRESS_WIDTH,
  parameter int REQUESTERS    = DEF_REQUESTERS,
  parameter int LENGTH_WIDTH  = DEF_LENGTH_WIDTH
) (
  input  logic                    ReadClock,
  input  logic                    Reset,
  pdp_read_burst_arbiter_if.slave bus
);

  localparam int                     DEPTH_LAST   = MEMORY_DEPTH - 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W      = MEMORY_DEPTH[ADDRESS_WIDTH:0];
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LAST_W = DEPTH_LAST[ADDRESS_WIDTH:0];
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO  = {ADDRESS_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE   = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LENGTH_WIDTH-1:0]  LEN_ZERO   = {LENGTH_WIDTH{1'b0}};
  localparam logic [LENGTH_WIDTH-1:0]  LEN_ONE    = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REQUESTERS-1:0]    REQ_ZERO   = {REQUESTERS{1'b0}};

  arb_state_e               state_r;
  logic [REQUESTERS-1:0]    grant_s;
  logic [REQUESTERS-1:0]    owner_r;
  logic [REQUESTERS-1:0]    ack_r;
  logic [REQUESTERS-1:0]    valid_r;
  logic [ADDRESS_WIDTH-1:0] start_raw_s;
  logic [ADDRESS_WIDTH-1:0] start_s;
  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [ADDRESS_WIDTH-1:0] addr_next_s;
  logic [LENGTH_WIDTH-1:0]  len_s;
  logic [LENGTH_WIDTH-1:0]  remain_r;
  logic                     issue_last_s;
  logic                     ren_r;
  logic                     busy_r;
  logic                     last_r;
  logic [DATA_WIDTH-1:0]    data_s;

`ifdef PDP_ARB_ROUND_ROBIN_EN
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(REQUESTERS - 1);
  logic [IDX_WIDTH-1:0]      ptr_r;
  logic [MAX_REQUESTERS-1:0] grant_ext_s;
  logic [IDX_WIDTH-1:0]      win_idx_s;

  pdp_rr_select #(.REQUESTERS(REQUESTERS)) u_select (
    .request (bus.Request_i),
    .pointer (ptr_r),
    .grant   (grant_s)
  );

  // Winner index, used to advance the round-robin pointer past the granted client.
  always_comb begin
    grant_ext_s                 = {MAX_REQUESTERS{1'b0}};
    grant_ext_s[REQUESTERS-1:0] = grant_s;
    win_idx_s                   = onehot_to_index(grant_ext_s);
  end

  // Pointer moves only when a burst is granted out of IDLE.
  always_ff @(posedge ReadClock or negedge Reset) begin
    if (!Reset) begin
      ptr_r <= 3'd0;
    end else if ((state_r == IDLE) && (grant_s != REQ_ZERO)) begin
      ptr_r <= (win_idx_s == LAST_IDX) ? 3'd0 : (win_idx_s + 3'd1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  pdp_rr_select #(.REQUESTERS(REQUESTERS)) u_select (
    .request (bus.Request_i),
    .grant   (grant_s)
  );
`endif

  // Winner's start address and length; out-of-range start addresses fold to 0.
  always_comb begin
    start_raw_s = ADDR_ZERO;
    len_s       = LEN_ZERO;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (grant_s[k]) begin
        start_raw_s = bus.Address_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        len_s       = bus.Length_i[k*LENGTH_WIDTH +: LENGTH_WIDTH];
      end else begin
        start_raw_s = start_raw_s;
        len_s       = len_s;
      end
    end
    if ({1'b0, start_raw_s} >= DEPTH_W) begin
      start_s = ADDR_ZERO;
    end else begin
      start_s = start_raw_s;
    end
  end

  // Next sequential address, wrapping at MEMORY_DEPTH which need not be a power of two.
  always_comb begin
    if ({1'b0, addr_r} == DEPTH_LAST_W) begin
      addr_next_s = ADDR_ZERO;
    end else begin
      addr_next_s = addr_r + ADDR_ONE;
    end
    issue_last_s = (remain_r == LEN_ZERO);
  end

  // Burst FSM with registered grant, enable, address and busy outputs.
  always_ff @(posedge ReadClock or negedge Reset) begin
    if (!Reset) begin
      state_r  <= IDLE;
      ack_r    <= REQ_ZERO;
      owner_r  <= REQ_ZERO;
      ren_r    <= 1'b0;
      busy_r   <= 1'b0;
      addr_r   <= ADDR_ZERO;
      remain_r <= LEN_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s != REQ_ZERO) begin
            state_r  <= BURST;
            ack_r    <= grant_s;
            owner_r  <= grant_s;
            ren_r    <= 1'b1;
            busy_r   <= 1'b1;
            addr_r   <= start_s;
            remain_r <= len_s;
          end else begin
            ack_r  <= REQ_ZERO;
            ren_r  <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        BURST: begin
          ack_r <= REQ_ZERO;
          if (issue_last_s) begin
            state_r <= IDLE;
            ren_r   <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            addr_r   <= addr_next_s;
            remain_r <= remain_r - LEN_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          ack_r   <= REQ_ZERO;
          ren_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Issue-side tag delayed one cycle so it lines up with the RAM's registered read data.
  always_ff @(posedge ReadClock or negedge Reset) begin
    if (!Reset) begin
      valid_r <= REQ_ZERO;
      last_r  <= 1'b0;
    end else if (ren_r) begin
      valid_r <= owner_r;
      last_r  <= issue_last_s;
    end else begin
      valid_r <= REQ_ZERO;
      last_r  <= 1'b0;
    end
  end

  assign data_s               = bus.RamData_i;
  assign bus.Data_o           = data_s;
  assign bus.Ack_o            = ack_r;
  assign bus.RamReadEnable_o  = ren_r;
  assign bus.RamReadAddress_o = addr_r;
  assign bus.DataValid_o      = valid_r;
  assign bus.Last_o           = last_r;
  assign bus.Busy_o           = busy_r;

endmodule

// File: doc/pdp_read_burst_arbiter.md
# pdp_read_burst_arbiter

Shares the read port of the pseudo-dual-port RAM between `REQUESTERS` clients. Each client issues a burst read as a start address plus a length. The arbiter grants one burst at a time and drives sequential RAM read addresses. Returned words are tagged to the owning client. It sits in the `ReadClock` domain, directly in front of the RAM read port; the write port is not touched.

## Interface
- `ADDRESS_WIDTH`, 16, RAM address width
- `DATA_WIDTH`, 8, RAM word width
- `MEMORY_DEPTH`, 2**ADDRESS_WIDTH, RAM words; wrap boundary
- `REQUESTERS`, 4, number of clients (2..8)
- `LENGTH_WIDTH`, 8, burst length field width

Ports:
- `ReadClock`  in  1  clock; RAM read clock
- `Reset`  in  1  reset Reset, asynchronous, active-low; clock ReadClock
- `Request_i`  in  REQUESTERS  per-client level request
- `Address_i`  in  REQUESTERS*ADDRESS_WIDTH  start address; client k at `[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]`
- `Length_i`  in  REQUESTERS*LENGTH_WIDTH  words minus one; client k at `[k*LENGTH_WIDTH +: LENGTH_WIDTH]`
- `RamData_i`  in  DATA_WIDTH  RAM read data
- `Ack_o`  out  REQUESTERS  one-hot, 1-cycle pulse: burst accepted
- `RamReadEnable_o`  out  1  to RAM `ReadEnable_i`
- `RamReadAddress_o`  out  ADDRESS_WIDTH  to RAM `ReadAddress_i`
- `Data_o`  out  DATA_WIDTH  `RamData_i` passed through combinationally
- `DataValid_o`  out  REQUESTERS  one-hot: `Data_o` belongs to client k this cycle
- `Last_o`  out  1  final word of burst, coincident with `DataValid_o`
- `Busy_o`  out  1  high while state is BURST

## Operation
- FSM states and transitions:
  - IDLE: if any `Request_i` bit is high at a clock edge, arbitrate and enter BURST.
  - BURST: enter IDLE at the edge after the last address has been issued.
- Grant at edge E0:
  - Sample the winner's `Address_i` and `Length_i`.
  - Set `Ack_o[k]=1` for one cycle and `Busy_o=1`.
  - Set `RamReadEnable_o=1` and `RamReadAddress_o` = start address.
- Address sequencing:
  - Issue one address per cycle; `Length_i+1` addresses in total. Length 0 means 1 word; maximum is 2**LENGTH_WIDTH words.
  - The address increments modulo `MEMORY_DEPTH`: `MEMORY_DEPTH-1` is followed by 0.
  - A start address of `MEMORY_DEPTH` or above is replaced by 0.
- Data return:
  - `DataValid_o` and `Last_o` are the issue-side enable and tag, registered one cycle.
  - They therefore align with the RAM's registered `Data_o`.
- Request handling:
  - The client deasserts `Request_i[k]` in its `Ack_o` cycle.
  - A request still high when the arbiter next sits in IDLE is a new burst.
  - A request dropped before `Ack_o` is never served and is not an error.
  - `Request_i` is ignored while in BURST.
- Arbitration: see Configuration.

## Timing
- Reset (async, immediate): state IDLE, pointer 0, and all outputs 0 (`Ack_o`, `RamReadEnable_o`, `RamReadAddress_o`, `DataValid_o`, `Last_o`, `Busy_o`). `Data_o` follows the RAM, which is also reset to 0.
- Latency:
  - Request sampled at E0; first address during E0→E1.
  - First `DataValid_o` during E1→E2.
  - Last word of an L+1 burst valid during E(L+1)→E(L+2).
- Between bursts: one cycle with `RamReadEnable_o=0`. Back-to-back bursts are spaced `Length+2` cycles start-to-start.
- Reset mid-burst: the burst is abandoned and in-flight data is discarded (`DataValid_o=0`). Clients must re-request after release.
- Reset release: the first arbitration happens at the first edge after deassertion.

## Configuration
- `PDP_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The search starts at the pointer; after a grant to k, the pointer becomes (k+1) mod `REQUESTERS`.
  - No client waits more than `REQUESTERS-1` bursts.
- `PDP_ARB_ROUND_ROBIN_EN` undefined: fixed priority.
  - The lowest index wins; the pointer register is not built.

## Structure
- Package `pdp_arb_pkg` holds:
  - State enum (IDLE, BURST).
  - Default width constants.
  - Function `onehot_to_index`.
- Sub-module `pdp_rr_select`:
  - Inputs: request vector and pointer.
  - Output: one-hot winner (combinational).
  - Implements fixed priority when the macro is undefined.
- The top holds the FSM, address and length counters, and the one-cycle tag pipeline.

## Test plan
The bench preloads the RAM through the write port with Memory[i] = i[7:0], using a RAM with 1-cycle read latency.
- Single burst: `Request_i`=0001, Address 0x0010, Length 3 -> `Ack_o[0]` for 1 cycle; addresses 0x10..0x13 over 4 cycles; `DataValid_o`=0001 for 4 cycles one cycle later with data 0x10..0x13; `Last_o` on 0x13 only.
- Wrap (ADDRESS_WIDTH 4, MEMORY_DEPTH 12): Address 10, Length 3 -> addresses 10, 11, 0, 1; data 0x0A, 0x0B, 0x00, 0x01.
- Contention with macro defined: `Request_i`=1111 held, all Length 0 -> grant order 0, 1, 2, 3, 0, with one idle cycle between bursts.
- Contention with macro undefined: `Request_i`=0110 held -> client 1 granted repeatedly; client 2 granted only after `Request_i[1]` drops.
- Reset mid-burst: client 2, Length 7, `Reset` low during word 3 -> all outputs 0 immediately, no further `DataValid_o`; after release, a held `Request_i`=0100 produces `Ack_o`=0100 at the first edge.
- Maximum length: Length 255, Address 0xFFF0 (ADDRESS_WIDTH 16) -> 256 valid words wrapping after 0xFFFF to 0x0000; `Last_o` exactly once, on address 0x00EF.
